// File: rtl/fmul_wb_buffer.sv
// ---------------------------------------------------------------------------
// fmul_wb_buffer
// Small FIFO that holds fmul results until writeback accepts them. Each
// entry stores {result, destination tag, overflow flag}. An entry's overflow
// flag is set when two finite operands produce a result with exponent 255.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    fmul result offered          in_ready  buffer not full
//   in_x1/in_x2 fmul operands (IEEE single)   in_y      fmul result
//   in_rd       destination register tag
//   out_valid   head entry valid              out_ready writeback accepts head
//   out_data    head result                   out_rd    head tag
//   out_ovf     head overflow flag
//   count       current occupancy (0..DEPTH)
//   ovf_clr     clears the sticky overflow flag
//   ovf_sticky  sticky overflow flag
//
// Configuration
//   FMUL_WB_OVF_STICKY_EN  when defined, ovf_sticky is set by any push whose
//                          overflow flag is 1 and cleared by ovf_clr (set
//                          wins). When undefined, ovf_sticky is tied to 0
//                          and ovf_clr is ignored.
// ---------------------------------------------------------------------------
module fmul_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_x1,
    input  logic [31:0]                in_x2,
    input  logic [31:0]                in_y,
    input  logic [TAG_W-1:0]           in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [TAG_W-1:0]           out_rd,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       ovf_clr,
    output logic                       ovf_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] rd_mem   [DEPTH];
    logic             ovf_mem  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          ovf;
    logic          push;
    logic          pop;
    logic          not_empty;

    // Finite * finite product that saturated to exponent 255.
    assign ovf = (in_x1[30:23] != 8'hFF) && (in_x2[30:23] != 8'hFF) &&
                 (in_y[30:23] == 8'hFF);

    assign not_empty = (count != '0);

    // Handshakes are masked by rst so nothing moves while reset is held;
    // in_ready ignores the same-cycle pop (no bypass when full).
    assign in_ready  = rst || (count != FULL);
    assign out_valid = !rst && not_empty;
    assign push      = !rst && in_valid && (count != FULL);
    assign pop       = out_valid && out_ready;

    assign out_data = out_valid ? data_mem[rd_ptr] : 32'd0;
    assign out_rd   = out_valid ? rd_mem[rd_ptr]   : '0;
    assign out_ovf  = out_valid ? ovf_mem[rd_ptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_y;
            rd_mem[wr_ptr]   <= in_rd;
            ovf_mem[wr_ptr]  <= ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FMUL_WB_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (push && ovf)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end
`else
    assign ovf_sticky = 1'b0;
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    // Only the exponent fields of the operands matter here.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{in_x1[31], in_x1[22:0], in_x2[31], in_x2[22:0]};

endmodule

// File: tb/tb_fmul_wb_buffer.sv
module tb_fmul_wb_buffer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
`ifdef FMUL_WB_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1, in_x2, in_y;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_rd;
    logic             out_ovf;
    logic [2:0]       count;
    logic             ovf_clr;
    logic             ovf_sticky;

    int errors = 0;
    int checks = 0;

    fmul_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_y(in_y), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_ovf(out_ovf),
        .count(count), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_plain(input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_x1    = 32'h3F800000;
        in_x2    = 32'h3F800000;
        in_y     = 32'h3F800000 + {26'd0, tag};
        in_rd    = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        in_x1 = 32'h7F000000; in_x2 = 32'h7F000000; in_y = 32'h7F800000; in_rd = 6'd9;
        tick(); tick();
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'd0)  begin errors++; $display("FAIL rst_out_data: got %h exp 0", out_data); end
        checks++; if (out_rd !== 6'd0)     begin errors++; $display("FAIL rst_out_rd: got %0d exp 0", out_rd); end
        checks++; if (out_ovf !== 1'b0)    begin errors++; $display("FAIL rst_out_ovf: got %b exp 0", out_ovf); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b exp 0", ovf_sticky); end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic(input string nm);
        out_ready = 1'b1;
        in_valid = 1'b1; in_x1 = 32'h40000000; in_x2 = 32'h40400000; in_y = 32'h40C00000; in_rd = 6'd5;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL %s_valid: got %b exp 1", nm, out_valid); end
        checks++; if (out_data !== 32'h40C00000) begin errors++; $display("FAIL %s_data: got %h exp 40c00000", nm, out_data); end
        checks++; if (out_rd !== 6'd5)           begin errors++; $display("FAIL %s_rd: got %0d exp 5", nm, out_rd); end
        checks++; if (out_ovf !== 1'b0)          begin errors++; $display("FAIL %s_ovf: got %b exp 0", nm, out_ovf); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 32'd0)
            begin errors++; $display("FAIL %s_empty: got valid=%b count=%0d data=%h exp 0 0 0", nm, out_valid, count, out_data); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        in_valid = 1'b1; in_x1 = 32'h7F000000; in_x2 = 32'h7F000000; in_y = 32'h7F800000; in_rd = 6'd7;
        tick();
        in_valid = 1'b0;
        checks++; if (out_ovf !== 1'b1)      begin errors++; $display("FAIL ovf_flag: got %b exp 1", out_ovf); end
        checks++; if (out_data !== 32'h7F800000) begin errors++; $display("FAIL ovf_data: got %h exp 7f800000", out_data); end
        checks++; if (ovf_sticky !== STICKY) begin errors++; $display("FAIL ovf_sticky_set: got %b exp %b", ovf_sticky, STICKY); end
        tick();
        checks++; if (out_ovf !== 1'b1)      begin errors++; $display("FAIL ovf_hold: got %b exp 1", out_ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0)   begin errors++; $display("FAIL ovf_sticky_clr: got %b exp 0", ovf_sticky); end
        out_ready = 1'b1;
        tick();
        // Infinite operand: result at exponent 255 is not an fmul overflow.
        out_ready = 1'b0;
        in_valid = 1'b1; in_x1 = 32'h7F800000; in_x2 = 32'h3F800000; in_y = 32'h7F800000; in_rd = 6'd8;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ovf !== 1'b0)
            begin errors++; $display("FAIL inf_ovf: got valid=%b ovf=%b exp 1 0", out_valid, out_ovf); end
        checks++; if (ovf_sticky !== 1'b0)   begin errors++; $display("FAIL inf_sticky: got %b exp 0", ovf_sticky); end
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd0)        begin errors++; $display("FAIL inf_drain: got %0d exp 0", count); end
    endtask

    task automatic test_full_wrap();
        for (int round = 0; round < 3; round++) begin
            out_ready = 1'b0;
            for (int t = 1; t <= 5; t++) begin
                drive_plain(6'(t));
                tick();
                checks++; if (count !== 3'((t > 4) ? 4 : t))
                    begin errors++; $display("FAIL full_count r%0d t%0d: got %0d exp %0d", round, t, count, (t > 4) ? 4 : t); end
            end
            in_valid = 1'b0;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready r%0d: got %b exp 0", round, in_ready); end
            out_ready = 1'b1;
            for (int t = 1; t <= 4; t++) begin
                checks++; if (out_rd !== 6'(t) || out_data !== 32'h3F800000 + t)
                    begin errors++; $display("FAIL wrap_order r%0d: got rd=%0d data=%h exp rd=%0d", round, out_rd, out_data, t); end
                tick();
            end
            checks++; if (count !== 3'd0 || out_valid !== 1'b0)
                begin errors++; $display("FAIL wrap_empty r%0d: got count=%0d valid=%b exp 0 0", round, count, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_plain(6'd11); tick();
        drive_plain(6'd12); tick();
        drive_plain(6'd13); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd2)  begin errors++; $display("FAIL simul_count: got %0d exp 2", count); end
        checks++; if (out_rd !== 6'd12) begin errors++; $display("FAIL simul_head: got %0d exp 12", out_rd); end
        tick();
        checks++; if (out_rd !== 6'd13) begin errors++; $display("FAIL simul_order: got %0d exp 13", out_rd); end
        tick();
        // Full buffer with pop and push offered: only the pop happens.
        out_ready = 1'b0;
        for (int t = 21; t <= 24; t++) begin drive_plain(6'(t)); tick(); end
        drive_plain(6'd25); out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd3)    begin errors++; $display("FAIL fullpop_count: got %0d exp 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready: got %b exp 1", in_ready); end
        out_ready = 1'b1;
        for (int t = 22; t <= 24; t++) begin
            checks++; if (out_rd !== 6'(t)) begin errors++; $display("FAIL fullpop_order: got %0d exp %0d", out_rd, t); end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fullpop_drain: got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; in_x1 = 32'h7F000000; in_x2 = 32'h7F000000; in_y = 32'h7F800000; in_rd = 6'(30 + t);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_prefill: got %0d exp 3", count); end
        checks++; if (ovf_sticky !== STICKY) begin errors++; $display("FAIL mid_sticky: got %b exp %b", ovf_sticky, STICKY); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'd0)
            begin errors++; $display("FAIL mid_rst: got count=%0d valid=%b data=%h exp 0 0 0", count, out_valid, out_data); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky: got %b exp 0", ovf_sticky); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL mid_rst_in_ready: got %b exp 1", in_ready); end
        test_basic("post_rst");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_overflow();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
